// File: rtl/sprite_pkg.sv
// sprite_pkg: shared coordinate widths, direction encodings and sprite indices
package sprite_pkg;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam int SPR_PACMAN = 0;
  localparam int SPR_BLINKY = 1;
  localparam int SPR_PINKY  = 2;
  localparam int SPR_INKY   = 3;
  localparam int SPR_CLYDE  = 4;
  typedef enum logic {ST_IDLE, ST_MOVING} sprite_state_t;
endpackage

// File: rtl/sprite_motion_channel.sv
// sprite_motion_channel: per-sprite move FSM, step counter and position registers
module sprite_motion_channel
  import sprite_pkg::*;
#(
  parameter int STEP  = 16,
  parameter int SPEED = 2,
  parameter int X_MIN = 343,
  parameter int X_MAX = 1607,
  parameter int Y_MIN = 34,
  parameter int Y_MAX = 818,
  parameter logic [XW-1:0] HOME_X = '0,
  parameter logic [YW-1:0] HOME_Y = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic [3:0]    dir,
  input  logic          respawn,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          busy,
  output logic          done
);
  localparam int NSTEP = STEP / SPEED;
  localparam int CW = $clog2(NSTEP + 1);
  localparam logic [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic [XW:0] XLO = (XW+1)'(X_MIN);
  localparam logic [XW:0] XHI = (XW+1)'(X_MAX);
  localparam logic [YW:0] STEP_Y = (YW+1)'(STEP);
  localparam logic [YW:0] YLO = (YW+1)'(Y_MIN);
  localparam logic [YW:0] YHI = (YW+1)'(Y_MAX);
  localparam logic [XW-1:0] SPD_X = XW'(SPEED);
  localparam logic [YW-1:0] SPD_Y = YW'(SPEED);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);
  sprite_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] mdir;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  logic [XW:0] nx;
  logic [YW:0] ny;
  logic wrap, last;
  // one extra bit keeps out-of-bounds targets distinguishable from wrapped ones
  always_comb begin
    nx = dir == DIR_RIGHT ? {1'b0, pos_x} + STEP_X : dir == DIR_LEFT ? {1'b0, pos_x} - STEP_X : {1'b0, pos_x};
    ny = dir == DIR_DOWN ? {1'b0, pos_y} + STEP_Y : dir == DIR_UP ? {1'b0, pos_y} - STEP_Y : {1'b0, pos_y};
    wrap = nx > XHI || nx < XLO || ny > YHI || ny < YLO;
    last = cnt == LAST;
  end
  assign busy = state == ST_MOVING;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      mdir <= '0;
      tx <= '0;
      ty <= '0;
      pos_x <= HOME_X;
      pos_y <= HOME_Y;
      done <= 1'b0;
    end else if (respawn) begin
      state <= ST_IDLE;
      cnt <= '0;
      pos_x <= HOME_X;
      pos_y <= HOME_Y;
      done <= 1'b0;
    end else if (start) begin
      done <= wrap;
      mdir <= dir;
      cnt <= '0;
      if (wrap) begin
        pos_x <= dir == DIR_RIGHT ? XLO[XW-1:0] : dir == DIR_LEFT ? XHI[XW-1:0] : pos_x;
        pos_y <= dir == DIR_DOWN ? YLO[YW-1:0] : dir == DIR_UP ? YHI[YW-1:0] : pos_y;
      end else begin
        state <= ST_MOVING;
        tx <= nx[XW-1:0];
        ty <= ny[YW-1:0];
      end
    end else if (busy && tick) begin
      cnt <= cnt + 1'b1;
      done <= last;
      if (last) begin
        state <= ST_IDLE;
        pos_x <= tx;
        pos_y <= ty;
      end else begin
        pos_x <= mdir == DIR_RIGHT ? pos_x + SPD_X : mdir == DIR_LEFT ? pos_x - SPD_X : pos_x;
        pos_y <= mdir == DIR_DOWN ? pos_y + SPD_Y : mdir == DIR_UP ? pos_y - SPD_Y : pos_y;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/sprite_position_engine.sv
// sprite_position_engine: move-request decode and legality check feeding per-sprite motion channels
module sprite_position_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int STEP  = 16,
  parameter int SPEED = 2,
  parameter int X_MIN = 343,
  parameter int X_MAX = 1607,
  parameter int Y_MIN = 34,
  parameter int Y_MAX = 818,
  parameter logic [XW*NUM_SPRITES-1:0] RESET_X = {11'd615, 11'd503, 11'd615, 11'd663, 11'd967},
  parameter logic [YW*NUM_SPRITES-1:0] RESET_Y = {10'd370, 10'd66, 10'd258, 10'd434, 10'd66},
  localparam int IDW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      move_valid,
  output logic                      move_ready,
  input  logic [IDW-1:0]            move_sprite,
  input  logic [3:0]                move_dir,
  input  logic [3:0]                valid_moves,
  input  logic [NUM_SPRITES-1:0]    respawn,
  output logic [XW*NUM_SPRITES-1:0] pos_x,
  output logic [YW*NUM_SPRITES-1:0] pos_y,
  output logic [NUM_SPRITES-1:0]    busy,
  output logic [NUM_SPRITES-1:0]    done,
  output logic                      reject
);
  logic in_range, legal, accept;
  logic [NUM_SPRITES-1:0] start;
  // out-of-range indices are accepted so that they can be rejected
  always_comb begin
    in_range = {1'b0, move_sprite} < (IDW+1)'(NUM_SPRITES);
    move_ready = in_range ? !busy[move_sprite] && !respawn[move_sprite] : 1'b1;
    legal = in_range && $onehot(move_dir) && (move_dir & valid_moves) == move_dir;
    accept = move_valid && move_ready;
    start = accept && legal ? NUM_SPRITES'(1) << move_sprite : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reject <= 1'b0;
    else reject <= accept && !legal;
  end
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
    sprite_motion_channel #(
      .STEP(STEP), .SPEED(SPEED),
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .HOME_X(RESET_X[i*XW +: XW]), .HOME_Y(RESET_Y[i*YW +: YW])
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .start(start[i]),
      .dir(move_dir),
      .respawn(respawn[i]),
      .pos_x(pos_x[i*XW +: XW]),
      .pos_y(pos_y[i*YW +: YW]),
      .busy(busy[i]),
      .done(done[i])
    );
  end
endmodule
